// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage owning the 8x8 register file ahead of an external ALU
// Ports: clk/reset (sync, active-high); in_* decoded instruction with valid/ready;
//        alu_op/alu_a/alu_b drive the ALU from the execute register, alu_result returns;
//        out_* writeback entry (valid/ready), committed to the register file on retire.
// Option: ALU_EXEC_FWD_EN enables operand forwarding instead of hazard stalls.
module alu_exec_stage #(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_op,
    input  logic [2:0] in_rd,
    input  logic [2:0] in_rs1,
    input  logic [2:0] in_rs2,
    input  logic [7:0] in_imm,
    input  logic       in_use_imm,
    output logic [5:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_rd,
    output logic [7:0] out_data,
    output logic       out_zero
);
    logic       ex_valid, wb_valid;
    logic [5:0] ex_op;
    logic [7:0] ex_a, ex_b, wb_data;
    logic [2:0] ex_rd, wb_rd;
    logic [7:0] rf [NREGS];
    logic       wb_free, ex_adv, accept, retire, hazard_stall;
    logic [7:0] opa, opb;

    assign wb_free   = !wb_valid || out_ready;
    assign ex_adv    = ex_valid && wb_free;
    assign retire    = wb_valid && out_ready;
    assign in_ready  = (!ex_valid || ex_adv) && !hazard_stall;
    assign accept    = in_valid && in_ready;
    assign alu_op    = ex_op;
    assign alu_a     = ex_a;
    assign alu_b     = ex_b;
    assign out_valid = wb_valid;
    assign out_rd    = wb_rd;
    assign out_data  = wb_data;
    assign out_zero  = wb_data == 8'd0;

`ifdef ALU_EXEC_FWD_EN
    // youngest producer wins: EX result (still at the ALU) before WB data before the file
    function automatic logic [7:0] src(input logic [2:0] s);
        return s == 3'd0 ? 8'd0 :
               (ex_valid && ex_rd == s) ? alu_result :
               (wb_valid && wb_rd == s) ? wb_data : rf[s];
    endfunction
    assign hazard_stall = 1'b0;
`else
    // write-through keeps a same-cycle retire visible to the operand read
    function automatic logic [7:0] src(input logic [2:0] s);
        return s == 3'd0 ? 8'd0 : (retire && wb_rd == s) ? wb_data : rf[s];
    endfunction
    logic hz1, hz2;
    assign hz1 = in_rs1 != 3'd0 && ((ex_valid && ex_rd == in_rs1) || (wb_valid && wb_rd == in_rs1));
    assign hz2 = !in_use_imm && in_rs2 != 3'd0 &&
                 ((ex_valid && ex_rd == in_rs2) || (wb_valid && wb_rd == in_rs2));
    assign hazard_stall = hz1 || hz2;
`endif

    always_comb begin
        opa = src(in_rs1);
        opb = in_use_imm ? in_imm : src(in_rs2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            wb_valid <= 1'b0;
            ex_op    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
            wb_data  <= '0;
            wb_rd    <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                ex_valid <= 1'b1;
                ex_op    <= in_op;
                ex_a     <= opa;
                ex_b     <= opb;
                ex_rd    <= in_rd;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
            if (ex_adv) begin
                wb_valid <= 1'b1;
                wb_data  <= alu_result;
                wb_rd    <= ex_rd;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (retire && wb_rd != 3'd0) rf[wb_rd] <= wb_data;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench with an architectural reference model and a behavioural ALU
module tb_alu_exec_stage;
    logic       clk = 0, reset = 1, in_valid = 0, in_use_imm = 0, out_ready = 1;
    logic [5:0] in_op = 0, alu_op;
    logic [2:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0, out_rd;
    logic [7:0] in_imm = 0, alu_a, alu_b, alu_result, out_data;
    logic       in_ready, out_valid, out_zero;
    logic       rand_rdy = 0, hold_rdy = 1;
    int         n_chk = 0, n_fail = 0;
    logic [7:0] mr [8];
    logic [10:0] q [$];

    alu_exec_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'd0: return a | b;
            6'd1: return ~(a & b);
            6'd2: return ~(a | b);
            6'd3: return a & b;
            6'd4: return a + b;
            6'd5: return a - b;
            6'd6: return a ^ b;
            6'd7: return a << b[2:0];
            default: return 8'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // architectural model: instructions take effect in acceptance order
    task automatic model_accept(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic [7:0] imm, input logic ui);
        logic [7:0] r;
        r = alu_fn(op, mr[rs1], ui ? imm : mr[rs2]);
        if (rd != 0) mr[rd] = r;
        q.push_back({rd, r});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 8'd0;
        q.delete();
    endtask

    // caller sits at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm, input logic ui, output int waits);
        waits = 0;
        in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("issue_timeout", 32'd1, 32'd0);
        else model_accept(op, rd, rs1, rs2, imm, ui);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : hold_rdy;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", {out_rd, out_data}, 11'h7ff);
                else begin
                    logic [10:0] e;
                    e = q.pop_front();
                    chk("wb_entry", {out_rd, out_data, out_zero}, {e, e[7:0] == 8'd0});
                end
            end
        end
    end

    initial begin
        int w0, w1, acc, k;
        logic [2:0] snap_rd;
        logic [7:0] snap_data;
        model_reset();
        in_valid = 1; in_op = 6'd4; in_rd = 3'd1; in_imm = 8'h55; in_use_imm = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0; in_valid = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_fields", {out_rd, out_data, out_zero}, {3'd0, 8'd0, 1'b1});
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        @(posedge clk); #1;
        issue(6'd0, 3'd2, 3'd1, 3'd0, 8'h00, 1, w0);
        drain();

        issue(6'd4, 3'd1, 3'd0, 3'd0, 8'h05, 1, w0);
        @(negedge clk);
        chk("lat_ex_only", out_valid, 0);
        @(negedge clk);
        chk("lat_wb", {out_valid, out_rd, out_data, out_zero}, {1'b1, 3'd1, 8'h05, 1'b0});
        @(posedge clk); #1;
        issue(6'd5, 3'd2, 3'd1, 3'd0, 8'h05, 1, w0);
        drain();

        issue(6'd4, 3'd1, 3'd0, 3'd0, 8'h80, 1, w0);
        issue(6'd4, 3'd1, 3'd1, 3'd1, 8'h00, 0, w1);
        @(negedge clk);
`ifdef ALU_EXEC_FWD_EN
        chk("dep_waits", w1, 0);
        chk("b2b_valid", out_valid, 1);
`else
        chk("dep_waits", w1, 2);
        chk("b2b_valid", out_valid, 0);
`endif
        @(posedge clk); #1;
        drain();

        issue(6'd0, 3'd0, 3'd0, 3'd0, 8'hff, 1, w0);
        issue(6'd7, 3'd3, 3'd0, 3'd0, 8'h01, 1, w0);
        drain();

        hold_rdy = 0;
        acc = 0; k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = k < 3; in_op = 6'd4; in_rd = 3'(k + 5); in_rs1 = 0; in_imm = 8'(k + 16); in_use_imm = 1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_accept(6'd4, 3'(k + 5), 3'd0, 3'd0, 8'(k + 16), 1);
                k++;
                acc++;
            end
            if (c == 2) begin
                snap_rd = out_rd;
                snap_data = out_data;
            end
            if (c == 4) chk("bp_wb_stable", {out_valid, out_rd, out_data}, {1'b1, snap_rd, snap_data});
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("bp_accepted", acc, 2);
        hold_rdy = 1;
        drain();
        issue(6'd4, 3'd7, 3'd0, 3'd0, 8'h12, 1, w0);
        drain();

        issue(6'd4, 3'd4, 3'd0, 3'd0, 8'h33, 1, w0);
        @(posedge clk); #1;
        chk("mid_wb_valid", out_valid, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        @(negedge clk);
        chk("mid_out_valid", out_valid, 0);
        @(posedge clk); #1;
        issue(6'd0, 3'd5, 3'd4, 3'd0, 8'h00, 1, w0);
        drain();

        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            issue(r < 8 ? 6'(r) : 6'($urandom_range(8, 63)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), w0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 0;
        drain();
        for (int i = 1; i < 8; i++) issue(6'd0, 3'd0, 3'(i), 3'd0, 8'h00, 1, w0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
